// File: rtl/arbitro_rr_if.sv
// arbitro_rr_if: request/grant bundle between N bus masters and the arbiter.
//   req       : one bit per requester, high while it wants or keeps the bus
//   grant     : one-hot owner (all-zero when idle), drives the bus mux select
//   grant_num : binary index of the owner, 0 when idle
//   available : high when no grant is active
// Modports: master drives req, slave (the arbiter) drives the grant side.
interface arbitro_rr_if #(
  parameter int unsigned N = 4
) ();
  localparam int unsigned W = $clog2(N);

  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [W-1:0] grant_num;
  logic         available;

  modport master (
    output req,
    input  grant,
    input  grant_num,
    input  available
  );

  modport slave (
    input  req,
    output grant,
    output grant_num,
    output available
  );
endinterface

// File: rtl/arbitro_rr.sv
// arbitro_rr: registered N-way bus arbiter with fixed-priority or round-robin
// policy and an optional hold limit that forces handover under contention.
// Parameters:
//   N        : number of requesters (2..16)
//   MODE     : 0 = fixed priority (lowest index), 1 = round-robin
//   MAX_HOLD : max cycles an owner keeps the bus while others wait, 0 = no limit
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : arbitro_rr_if slave side (req in; grant, grant_num, available out)
module arbitro_rr #(
  parameter int unsigned N        = 4,
  parameter int unsigned MODE     = 1,
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  arbitro_rr_if.slave  bus
);

  localparam int unsigned W  = $clog2(N);
  localparam int unsigned CW = 8;
  // Counter value at which a contended owner must hand over.
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? CW'(0) : CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [W-1:0]    ptr;
  logic [W-1:0]    ptr_d;
  logic [CW-1:0]   hold_cnt;
  logic [CW-1:0]   hold_cnt_d;
  logic [N-1:0]    grant_d;
  logic [W-1:0]    grant_num_d;
  logic            available_d;

  logic            new_grant;
  logic [W-1:0]    win;
  logic [N-1:0]    others;
  logic            owner_req;
  logic            hold_expired;
  logic [W:0]      sel_rel;
  logic [W:0]      sel_pre;

  // Winner search: returns {found, index}. MODE 0 scans from 0, MODE 1 from start.
  function automatic logic [W:0] pick(input logic [N-1:0] cand, input logic [W-1:0] start);
    logic         found;
    logic [W-1:0] idx;
    int unsigned  pos;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (MODE == 0) ? k : ((32'(start) + k) % N);
      if (!found && cand[W'(pos)]) begin
        found = 1'b1;
        idx   = W'(pos);
      end
    end
    return {found, idx};
  endfunction

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      bus.grant     <= '0;
      bus.grant_num <= '0;
      bus.available <= 1'b1;
    end else begin
      state         <= state_d;
      ptr           <= ptr_d;
      hold_cnt      <= hold_cnt_d;
      bus.grant     <= grant_d;
      bus.grant_num <= grant_num_d;
      bus.available <= available_d;
    end
  end

  // Next-state: decide whether a new grant happens and who wins it.
  // The registered one-hot grant doubles as the owner mask. While BUSY, ptr
  // already holds owner+1, so the preempt search starts just past the owner.
  always_comb begin
    state_d      = state;
    new_grant    = 1'b0;
    win          = '0;
    others       = bus.req & ~bus.grant;
    owner_req    = |(bus.req & bus.grant);
    hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    sel_rel      = pick(bus.req, ptr);
    sel_pre      = pick(others, ptr);
    case (state)
      IDLE: begin
        if (sel_rel[W]) begin
          state_d   = BUSY;
          new_grant = 1'b1;
          win       = sel_rel[W-1:0];
        end
      end
      BUSY: begin
        if (!owner_req) begin
          // Release: hand over on the same edge, or go idle.
          if (sel_rel[W]) begin
            new_grant = 1'b1;
            win       = sel_rel[W-1:0];
          end else begin
            state_d = IDLE;
          end
        end else if (hold_expired && sel_pre[W]) begin
          new_grant = 1'b1;
          win       = sel_pre[W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath: next values of the registered outputs, pointer and counter.
  always_comb begin
    grant_d     = bus.grant;
    grant_num_d = bus.grant_num;
    available_d = bus.available;
    ptr_d       = ptr;
    hold_cnt_d  = hold_cnt;
    if (state_d == IDLE) begin
      grant_d     = '0;
      grant_num_d = '0;
      available_d = 1'b1;
      hold_cnt_d  = '0;
    end else if (new_grant) begin
      grant_d     = N'(1) << win;
      grant_num_d = win;
      available_d = 1'b0;
      hold_cnt_d  = '0;
      ptr_d       = (win == W'(N - 1)) ? '0 : win + W'(1);
    end else if (hold_cnt < HOLD_LAST) begin
      // Same owner kept: count tenure, saturating at the handover point.
      hold_cnt_d = hold_cnt + CW'(1);
    end
  end

endmodule

// File: doc/arbitro_rr.md
# arbitro_rr

Parametrised, registered bus arbiter for N requesters sharing one bus. It supports fixed-priority and round-robin policies, holds a grant while the owner keeps requesting, and has an optional hold limit that forces handover when others are waiting. It sits between the requesting masters and the shared-bus mux; `grant`/`grant_num` drive the mux select directly.

## Interface
- `N`, default 4: number of requesters. Legal range 2..16.
- `MODE`, default 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `MAX_HOLD`, default 0: maximum cycles an owner keeps the bus while others request. 0 = unlimited. Legal range 0..255.
- `W` (localparam) = $clog2(N).
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, N: request vector; bit i high = requester i wants or keeps the bus.
- `grant`, output, N: registered one-hot grant, or all-zero when idle.
- `grant_num`, output, W: registered binary index of owner. Equals 0 when idle.
- `available`, output, 1: registered; 1 when no grant is active (`grant == 0`).

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner = `grant_num`.
- Winner selection (combinational, over candidate vector `cand`):
  - MODE 0: lowest set index.
  - MODE 1: first set index searching `ptr`, `ptr+1`, …, wrapping N-1 → 0.
- Round-robin pointer `ptr` (W bits):
  - On every new grant to index k, `ptr` ← (k+1) mod N; the wrap from N-1 goes to 0.
  - Unused in MODE 0.
- Transitions from IDLE:
  - `req == 0`: stay IDLE.
  - Otherwise: BUSY with winner of `cand = req`.
- Transitions from BUSY (owner o):
  - `req[o] == 0` (release), with `cand = req` nonzero: grant winner of `cand` at the same edge. No idle cycle.
  - `req[o] == 0` and `req == 0`: IDLE.
  - `req[o] == 1`, `MAX_HOLD != 0`, `hold_cnt == MAX_HOLD-1`, and `req & ~onehot(o)` nonzero: preempt. Grant the winner of `cand = req & ~onehot(o)`; in MODE 1 the search starts at `ptr = o+1`.
  - Otherwise: keep owner.
- Hold counter `hold_cnt` (8 bits):
  - Cleared to 0 on every new grant.
  - Increments each cycle the same owner is kept; saturates at MAX_HOLD-1.
  - Ignored when MAX_HOLD = 0.
- A requester dropping and re-raising `req` while not owner has no memory effect. Arbitration uses only the current `req`.
- Exactly one or zero bits of `grant` are set at all times.

## Timing
- Reset (asynchronous assert; deassert is synchronised externally):
  - `grant` = 0, `grant_num` = 0, `available` = 1.
  - `ptr` = 0, `hold_cnt` = 0, state IDLE.
- Reset mid-grant drops `grant` immediately. First grant after reset uses `ptr` = 0.
- Latency:
  - `req` sampled at edge t; `grant` visible after edge t.
  - 1-cycle request-to-grant from IDLE.
  - 1-cycle release-to-handover.
- With contention and MAX_HOLD = H > 0, an owner holds exactly H cycles, then switches.
- Uncontended owner holds indefinitely; the counter stays saturated.
- If the contender vanishes in the preempt cycle, no preemption occurs.
- `available` and `grant` change on the same edge.

## Test plan
- Reset: drive `req = 4'hF` during `rst_n = 0` → `grant = 0`, `grant_num = 0`, `available = 1`. First edge after release → `grant = 4'b0001`, `available = 0`.
- Fixed priority (MODE 0, N = 4): `req = 4'b1010` → `grant = 4'b0010`, `grant_num = 1`. Drop `req[1]` → next cycle `grant = 4'b1000`, `grant_num = 3`. Drop all → `available = 1` the cycle after.
- Round-robin rotation (MODE 1, N = 4, MAX_HOLD = 2): hold `req = 4'hF` → `grant_num` sequence 0,0,1,1,2,2,3,3,0,0, each owner for exactly 2 cycles.
- Wrap-around (MODE 1, N = 8, MAX_HOLD = 0): grant 7 via `req = 8'h80`, then `req = 8'h81` with `req[7]` dropped → `grant_num = 0`. Pointer wraps 7 → 0.
- Uncontended hold (MAX_HOLD = 3): `req = 4'b0100` held 10 cycles → `grant = 4'b0100` throughout. Then raise `req[0]` → handover to 0 within 1 cycle, since the counter is saturated.
- Reset mid-operation: assert `rst_n = 0` asynchronously while `grant = 4'b0100` → `grant = 0` before the next edge. After release with `req = 4'hC` → `grant = 4'b0100` (`ptr` reset to 0).
